// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
// Holds the FSM state encoding, event source codes, ExcCode values and the flush mask per source.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VECTOR  = 3'd1,
    ST_HANDLER = 3'd2,
    ST_RETURN  = 3'd3,
    ST_HALT    = 3'd4
  } exc_state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_OVF   = 2'd1,
    SRC_UNDEF = 2'd2,
    SRC_IRQ   = 2'd3
  } exc_src_t;

  localparam int unsigned EXC_CAUSE_W = 5;

  localparam logic [EXC_CAUSE_W-1:0] CAUSE_INT = 5'd0;
  localparam logic [EXC_CAUSE_W-1:0] CAUSE_RI  = 5'd10;
  localparam logic [EXC_CAUSE_W-1:0] CAUSE_OV  = 5'd12;

  // Bit order is {flush_if, flush_id, flush_ex}; older faults kill deeper stages.
  function automatic logic [2:0] flush_mask(input exc_src_t src);
    logic [2:0] mask;
    case (src)
      SRC_OVF:   mask = 3'b111;
      SRC_UNDEF: mask = 3'b110;
      SRC_IRQ:   mask = 3'b100;
      default:   mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder over the exception sources.
// Picks overflow, then undefined opcode, then an unmasked interrupt; returns source, PC and ExcCode.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic                   exc_ovf,
  input  logic [31:0]            exc_ovf_pc,
  input  logic                   exc_undef,
  input  logic [31:0]            exc_undef_pc,
  input  logic                   irq,
  input  logic [31:0]            irq_pc,
  input  logic                   ie,
  input  logic                   exl,
  output exc_src_t               src,
  output logic [31:0]            sel_pc,
  output logic [EXC_CAUSE_W-1:0] sel_cause
);

  // Fixed-priority selection; lower-priority sources are simply dropped.
  always_comb begin
    src       = SRC_NONE;
    sel_pc    = 32'h0000_0000;
    sel_cause = CAUSE_INT;
    if (exc_ovf) begin
      src       = SRC_OVF;
      sel_pc    = exc_ovf_pc;
      sel_cause = CAUSE_OV;
    end else if (exc_undef) begin
      src       = SRC_UNDEF;
      sel_pc    = exc_undef_pc;
      sel_cause = CAUSE_RI;
    end else if (irq && ie && !exl) begin
      src       = SRC_IRQ;
      sel_pc    = irq_pc;
      sel_cause = CAUSE_INT;
    end else begin
      src       = SRC_NONE;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: captures EPC/Cause, flushes the pipeline and
// steers the PC block's exception-vector load path for handler entry and eret.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_0180,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_ovf,
  input  logic [31:0]        exc_ovf_pc,
  input  logic               exc_undef,
  input  logic [31:0]        exc_undef_pc,
  input  logic               irq,
  input  logic [31:0]        irq_pc,
  input  logic               eret,
  input  logic               ie_wr,
  input  logic               ie_wdata,
  output logic               load_exceptn_vec_addr,
  output logic [31:0]        exception_vec_addr,
  output logic               flush_if,
  output logic               flush_id,
  output logic               flush_ex,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               exl,
  output logic               ie,
  output logic               double_fault
);

  exc_state_t               state_r, next_state_s;
  exc_src_t                 src_s;
  logic [31:0]              sel_pc_s;
  logic [EXC_CAUSE_W-1:0]   sel_cause_s;
  logic [31:0]              epc_r;
  logic [CAUSE_W-1:0]       cause_r;
  logic                     exl_r, ie_r, double_fault_r;
  logic                     load_s;
  logic [31:0]              vec_s;
  logic [2:0]               flush_s;
  logic                     fault_s;

  exc_prio_enc u_prio (
    .exc_ovf      (exc_ovf),
    .exc_ovf_pc   (exc_ovf_pc),
    .exc_undef    (exc_undef),
    .exc_undef_pc (exc_undef_pc),
    .irq          (irq),
    .irq_pc       (irq_pc),
    .ie           (ie_r),
    .exl          (exl_r),
    .src          (src_s),
    .sel_pc       (sel_pc_s),
    .sel_cause    (sel_cause_s)
  );

  // exl masks irq in HANDLER, so any selected source there is a synchronous fault.
  assign fault_s = (src_s == SRC_OVF) || (src_s == SRC_UNDEF);

  // State and architectural register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      epc_r          <= 32'h0000_0000;
      cause_r        <= '0;
      exl_r          <= 1'b0;
      ie_r           <= 1'b0;
      double_fault_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (ie_wr && (state_r != ST_HALT)) begin
        ie_r <= ie_wdata;
      end
      case (state_r)
        ST_IDLE: begin
          if (src_s != SRC_NONE) begin
            epc_r   <= sel_pc_s;
            cause_r <= CAUSE_W'(sel_cause_s);
            exl_r   <= 1'b1;
          end
        end
        ST_HANDLER: begin
          if (fault_s) begin
            double_fault_r <= 1'b1;
          end
        end
        ST_RETURN: exl_r <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state decision; inputs seen in VECTOR/RETURN belong to flushed instructions.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (src_s != SRC_NONE) next_state_s = ST_VECTOR;
        else                   next_state_s = ST_IDLE;
      end
      ST_VECTOR: next_state_s = ST_HANDLER;
      ST_HANDLER: begin
        if (fault_s)   next_state_s = ST_HALT;
        else if (eret) next_state_s = ST_RETURN;
        else           next_state_s = ST_HANDLER;
      end
      ST_RETURN: next_state_s = ST_IDLE;
      ST_HALT:   next_state_s = ST_HALT;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // PC override and flush outputs per state.
  always_comb begin
    load_s  = 1'b0;
    vec_s   = 32'h0000_0000;
    flush_s = 3'b000;
    case (state_r)
      ST_IDLE: flush_s = flush_mask(src_s);
      ST_VECTOR: begin
        load_s  = 1'b1;
        vec_s   = EXC_VEC;
        flush_s = 3'b100;
      end
      ST_HANDLER: begin
        vec_s   = EXC_VEC;
        flush_s = flush_mask(src_s);
      end
      ST_RETURN: begin
        load_s  = 1'b1;
        vec_s   = epc_r;
        flush_s = 3'b100;
      end
      ST_HALT: begin
        load_s = 1'b1;
        vec_s  = EXC_VEC;
      end
      default: begin
        load_s  = 1'b0;
        vec_s   = 32'h0000_0000;
        flush_s = 3'b000;
      end
    endcase
  end

  assign load_exceptn_vec_addr = load_s;
  assign exception_vec_addr    = vec_s;
  assign flush_if              = flush_s[2];
  assign flush_id              = flush_s[1];
  assign flush_ex              = flush_s[0];
  assign epc                   = epc_r;
  assign cause                 = cause_r;
  assign exl                   = exl_r;
  assign ie                    = ie_r;
  assign double_fault          = double_fault_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_ovf = 1'b0;
  logic [31:0] exc_ovf_pc = 32'h0;
  logic        exc_undef = 1'b0;
  logic [31:0] exc_undef_pc = 32'h0;
  logic        irq = 1'b0;
  logic [31:0] irq_pc = 32'h0;
  logic        eret = 1'b0;
  logic        ie_wr = 1'b0;
  logic        ie_wdata = 1'b0;
  logic        load_exceptn_vec_addr;
  logic [31:0] exception_vec_addr;
  logic        flush_if, flush_id, flush_ex;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        exl, ie, double_fault;

  int checks = 0;
  int failures = 0;

  exc_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .exc_ovf               (exc_ovf),
    .exc_ovf_pc            (exc_ovf_pc),
    .exc_undef             (exc_undef),
    .exc_undef_pc          (exc_undef_pc),
    .irq                   (irq),
    .irq_pc                (irq_pc),
    .eret                  (eret),
    .ie_wr                 (ie_wr),
    .ie_wdata              (ie_wdata),
    .load_exceptn_vec_addr (load_exceptn_vec_addr),
    .exception_vec_addr    (exception_vec_addr),
    .flush_if              (flush_if),
    .flush_id              (flush_id),
    .flush_ex              (flush_ex),
    .epc                   (epc),
    .cause                 (cause),
    .exl                   (exl),
    .ie                    (ie),
    .double_fault          (double_fault)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({epc, cause, exl, ie, double_fault} !== {32'h0, 5'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_regs epc=%h cause=%0d exl=%b ie=%b df=%b expected all 0", epc, cause, exl, ie, double_fault);
    end
    checks++;
    if ({load_exceptn_vec_addr, flush_if, flush_id, flush_ex} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b expected=0000", {load_exceptn_vec_addr, flush_if, flush_id, flush_ex});
    end
  endtask

  task automatic test_overflow();
    exc_ovf = 1'b1; exc_ovf_pc = 32'h40;
    #1;
    checks++;
    if ({flush_if, flush_id, flush_ex} !== 3'b111) begin
      failures++;
      $display("FAIL ovf_flush got=%b expected=111", {flush_if, flush_id, flush_ex});
    end
    tick();
    // In VECTOR: a new overflow here comes from a flushed instruction.
    exc_ovf_pc = 32'h88;
    #1;
    checks++;
    if ({load_exceptn_vec_addr, exception_vec_addr} !== {1'b1, 32'h180}) begin
      failures++;
      $display("FAIL ovf_vector load=%b vec=%h expected load=1 vec=00000180", load_exceptn_vec_addr, exception_vec_addr);
    end
    checks++;
    if ({epc, cause, exl} !== {32'h40, 5'd12, 1'b1}) begin
      failures++;
      $display("FAIL ovf_capture epc=%h cause=%0d exl=%b expected epc=00000040 cause=12 exl=1", epc, cause, exl);
    end
    checks++;
    if ({flush_if, flush_id, flush_ex} !== 3'b100) begin
      failures++;
      $display("FAIL vector_flush got=%b expected=100", {flush_if, flush_id, flush_ex});
    end
    tick();
    exc_ovf = 1'b0;
    #1;
    checks++;
    if ({load_exceptn_vec_addr, exception_vec_addr, epc, double_fault} !== {1'b0, 32'h180, 32'h40, 1'b0}) begin
      failures++;
      $display("FAIL ovf_ignored_in_vector load=%b vec=%h epc=%h df=%b expected 0/00000180/00000040/0", load_exceptn_vec_addr, exception_vec_addr, epc, double_fault);
    end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    checks++;
    if ({load_exceptn_vec_addr, exception_vec_addr, flush_if, exl} !== {1'b1, 32'h40, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ovf_return load=%b vec=%h fif=%b exl=%b expected 1/00000040/1/1", load_exceptn_vec_addr, exception_vec_addr, flush_if, exl);
    end
    tick();
    checks++;
    if ({load_exceptn_vec_addr, exl} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_back_idle load=%b exl=%b expected 0/0", load_exceptn_vec_addr, exl);
    end
  endtask

  task automatic test_undef();
    ie_wr = 1'b1; ie_wdata = 1'b1;
    tick();
    ie_wr = 1'b0;
    checks++;
    if (ie !== 1'b1) begin
      failures++;
      $display("FAIL ie_write got=%b expected=1", ie);
    end
    exc_undef = 1'b1; exc_undef_pc = 32'h24;
    irq = 1'b1; irq_pc = 32'h30;
    #1;
    checks++;
    if ({flush_if, flush_id, flush_ex} !== 3'b110) begin
      failures++;
      $display("FAIL undef_flush got=%b expected=110", {flush_if, flush_id, flush_ex});
    end
    tick();
    exc_undef = 1'b0;
    checks++;
    if ({epc, cause, exl, load_exceptn_vec_addr} !== {32'h24, 5'd10, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL undef_capture epc=%h cause=%0d exl=%b load=%b expected 00000024/10/1/1", epc, cause, exl, load_exceptn_vec_addr);
    end
    tick();
    checks++;
    if ({flush_if, flush_id, flush_ex, load_exceptn_vec_addr} !== 4'b0000) begin
      failures++;
      $display("FAIL irq_masked_by_exl got=%b expected=0000", {flush_if, flush_id, flush_ex, load_exceptn_vec_addr});
    end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++;
    if ({load_exceptn_vec_addr, exception_vec_addr, exl} !== {1'b1, 32'h24, 1'b1}) begin
      failures++;
      $display("FAIL undef_return load=%b vec=%h exl=%b expected 1/00000024/1", load_exceptn_vec_addr, exception_vec_addr, exl);
    end
    tick();
    // Pending irq is taken in the first IDLE cycle after RETURN.
    checks++;
    if ({exl, flush_if, flush_id, flush_ex} !== 4'b0100) begin
      failures++;
      $display("FAIL irq_reaccept exl/flush got=%b expected=0100", {exl, flush_if, flush_id, flush_ex});
    end
    tick();
    irq = 1'b0;
    checks++;
    if ({epc, cause} !== {32'h30, 5'd0}) begin
      failures++;
      $display("FAIL irq_reaccept_capture epc=%h cause=%0d expected 00000030/0", epc, cause);
    end
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_irq_mask();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    irq = 1'b1; irq_pc = 32'h100;
    #1;
    checks++;
    if ({flush_if, flush_id, flush_ex} !== 3'b000) begin
      failures++;
      $display("FAIL irq_masked_flush got=%b expected=000", {flush_if, flush_id, flush_ex});
    end
    tick();
    checks++;
    if ({exl, load_exceptn_vec_addr} !== 2'b00) begin
      failures++;
      $display("FAIL irq_masked_state exl=%b load=%b expected 0/0", exl, load_exceptn_vec_addr);
    end
    ie_wr = 1'b1; ie_wdata = 1'b1;
    #1;
    checks++;
    if (flush_if !== 1'b0) begin
      failures++;
      $display("FAIL irq_old_ie flush_if=%b expected=0", flush_if);
    end
    tick();
    ie_wr = 1'b0;
    #1;
    checks++;
    if ({ie, flush_if, flush_id, flush_ex} !== 4'b1100) begin
      failures++;
      $display("FAIL irq_accept ie/flush got=%b expected=1100", {ie, flush_if, flush_id, flush_ex});
    end
    tick();
    irq = 1'b0;
    checks++;
    if ({epc, cause, exl} !== {32'h100, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL irq_capture epc=%h cause=%0d exl=%b expected 00000100/0/1", epc, cause, exl);
    end
    tick();
  endtask

  // Entered in HANDLER with epc=0x100, cause=0.
  task automatic test_nested();
    exc_ovf = 1'b1; exc_ovf_pc = 32'h200;
    #1;
    checks++;
    if ({flush_if, flush_id, flush_ex} !== 3'b111) begin
      failures++;
      $display("FAIL nested_flush got=%b expected=111", {flush_if, flush_id, flush_ex});
    end
    tick();
    exc_ovf = 1'b0;
    checks++;
    if ({double_fault, load_exceptn_vec_addr, exception_vec_addr} !== {1'b1, 1'b1, 32'h180}) begin
      failures++;
      $display("FAIL halt_entry df=%b load=%b vec=%h expected 1/1/00000180", double_fault, load_exceptn_vec_addr, exception_vec_addr);
    end
    checks++;
    if ({epc, cause} !== {32'h100, 5'd0}) begin
      failures++;
      $display("FAIL halt_keeps_epc epc=%h cause=%0d expected 00000100/0", epc, cause);
    end
    eret = 1'b1; ie_wr = 1'b1; ie_wdata = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    eret = 1'b0; ie_wr = 1'b0;
    checks++;
    if ({double_fault, load_exceptn_vec_addr, exception_vec_addr, ie} !== {1'b1, 1'b1, 32'h180, 1'b1}) begin
      failures++;
      $display("FAIL halt_pinned df=%b load=%b vec=%h ie=%b expected 1/1/00000180/1", double_fault, load_exceptn_vec_addr, exception_vec_addr, ie);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({double_fault, load_exceptn_vec_addr, exl} !== 3'b000) begin
      failures++;
      $display("FAIL halt_reset df/load/exl got=%b expected=000", {double_fault, load_exceptn_vec_addr, exl});
    end
  endtask

  task automatic test_reset_mid();
    ie_wr = 1'b1; ie_wdata = 1'b1;
    exc_ovf = 1'b1; exc_ovf_pc = 32'h5c;
    tick();
    exc_ovf = 1'b0; ie_wr = 1'b0;
    checks++;
    if (load_exceptn_vec_addr !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_vector load=%b expected=1", load_exceptn_vec_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({epc, cause, exl, ie, double_fault, load_exceptn_vec_addr, flush_if, flush_id, flush_ex} !== {32'h0, 5'd0, 7'b0}) begin
      failures++;
      $display("FAIL mid_reset epc=%h cause=%0d flags=%b expected all 0", epc, cause, {exl, ie, double_fault, load_exceptn_vec_addr, flush_if, flush_id, flush_ex});
    end
    eret = 1'b1;
    #1;
    checks++;
    if ({load_exceptn_vec_addr, flush_if} !== 2'b00) begin
      failures++;
      $display("FAIL eret_idle_comb got=%b expected=00", {load_exceptn_vec_addr, flush_if});
    end
    tick();
    eret = 1'b0;
    checks++;
    if ({load_exceptn_vec_addr, exl, epc} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL eret_idle_ignored load=%b exl=%b epc=%h expected 0/0/00000000", load_exceptn_vec_addr, exl, epc);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_undef();
    test_irq_mask();
    test_nested();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer for the MIPS fetch stage.
- Watches the exception sources: ALU overflow (EX stage), reserved/undefined instruction (ID stage) and the external interrupt.
- Captures EPC and Cause, drives pipeline flushes, and steers the PC block through its exception-vector load path (load_exceptn_vec_addr / exception_vec_addr), both for handler entry and for eret return.
- Sits beside the PC block and the hazard unit; it is the only driver of the PC's exception-load inputs.

Parameters:
- EXC_VEC, 32'h0000_0180, byte address of the common exception handler.
- CAUSE_W, 5, width of the Cause (ExcCode) field.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- exc_ovf  in  1  overflow on the instruction currently in EX.
- exc_ovf_pc  in  32  byte PC of that EX instruction.
- exc_undef  in  1  undefined opcode decoded in ID.
- exc_undef_pc  in  32  byte PC of that ID instruction.
- irq  in  1  level-sensitive external interrupt request.
- irq_pc  in  32  PC of the next instruction to fetch (cur_pc of the PC block).
- eret  in  1  eret decoded in ID.
- ie_wr  in  1  write strobe for the interrupt-enable bit.
- ie_wdata  in  1  new interrupt-enable value.
- load_exceptn_vec_addr  out  1  PC override strobe.
- exception_vec_addr  out  32  PC override target.
- flush_if  out  1  kill the IF/ID register.
- flush_id  out  1  kill the ID/EX register.
- flush_ex  out  1  kill the EX/MEM register.
- epc  out  32  exception program counter.
- cause  out  CAUSE_W  ExcCode of the last accepted event.
- exl  out  1  exception level (handler active).
- ie  out  1  interrupt enable.
- double_fault  out  1  sticky fatal status; also the halt indication.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; epc=0, cause=0, exl=0, ie=0, double_fault=0. All strobes and flushes are 0. Reset applies from any state, including mid-VECTOR or mid-RETURN.
- States: IDLE, VECTOR, HANDLER, RETURN, HALT.
- Accept priority in IDLE: exc_ovf > exc_undef > (irq & ie & !exl). Only the highest-priority source is accepted; the others are dropped.
- Accept, cycle t (IDLE):
  - Combinational flushes: overflow asserts flush_if, flush_id, flush_ex; undef asserts flush_if, flush_id; irq asserts flush_if only.
  - At the end of cycle t: epc <= faulting PC (exc_ovf_pc, exc_undef_pc or irq_pc); cause <= CAUSE_OV (12), CAUSE_RI (10) or CAUSE_INT (0); exl <= 1; state <= VECTOR.
- VECTOR, cycle t+1: load_exceptn_vec_addr=1, exception_vec_addr=EXC_VEC, flush_if=1. Next state HANDLER. First handler fetch occurs in t+2.
- HANDLER:
  - exception_vec_addr holds EXC_VEC; strobes are 0.
  - irq is ignored (exl=1); the level stays pending.
  - eret in cycle t -> RETURN.
  - exc_ovf or exc_undef in cycle t -> HALT, with flushes as on accept. epc and cause are not overwritten.
- RETURN, cycle t+1: load_exceptn_vec_addr=1, exception_vec_addr=epc, flush_if=1. At the end of the cycle exl <= 0 and state <= IDLE.
- HALT:
  - double_fault=1 and load_exceptn_vec_addr=1 every cycle, with exception_vec_addr = EXC_VEC, i.e. the PC is pinned.
  - Exits only on rst.
- Exception inputs and eret arriving in VECTOR or RETURN come from flushed instructions and are ignored.
- An eret arriving in IDLE is ignored.
- ie_wr updates ie at the clock edge in any state except HALT.
- An irq accept uses the ie value before a same-cycle ie_wr.
- Since exl=1 until the end of the RETURN cycle, a pending irq is re-accepted no earlier than the cycle after RETURN.
- The hazard stall does not delay any transition: the PC block's exception mux overrides its stall path.
- EPC semantics: epc is the PC of the faulting instruction, not PC+4. The handler adjusts epc to skip the instruction.

Decomposition:
- Package exc_pkg holds:
  - state enum exc_state_t;
  - cause constants CAUSE_INT=0, CAUSE_RI=10, CAUSE_OV=12;
  - type exc_src_t {NONE, OVF, UNDEF, IRQ}.
- Sub-module exc_prio_enc: combinational priority encoder. Inputs: the three sources plus ie and exl. Outputs: exc_src_t, the selected PC, and the selected cause.

Test Plan:
- Overflow: exc_ovf=1, exc_ovf_pc=0x40, in IDLE.
  - Same cycle: all three flushes = 1.
  - Next cycle: load_exceptn_vec_addr=1, exception_vec_addr=0x180, epc=0x40, cause=12, exl=1.
- Undef: exc_undef=1 (pc 0x24) together with irq=1, ie=1.
  - epc=0x24, cause=10; flush_ex stays 0; the irq is dropped.
  - Then eret in HANDLER -> next cycle load_exceptn_vec_addr=1, exception_vec_addr=0x24, exl clears after that cycle.
- Interrupt masking:
  - irq=1 with ie=0 -> no action.
  - ie_wr=1, ie_wdata=1 -> accept in the cycle after the write; epc=irq_pc, cause=0, only flush_if=1.
- Nested fault: exc_ovf in HANDLER -> HALT; double_fault=1; epc and cause unchanged; PC pinned at 0x180 until rst.
- Reset mid-sequence: rst=1 during VECTOR -> next cycle all outputs are 0 and the state is IDLE.
- Ignored inputs: exc_ovf asserted in VECTOR -> ignored; eret asserted in IDLE -> ignored.
